// File: rtl/acc_datapath_mc_if.sv
// Command and memory handshake bundle for the multicycle accumulator datapath.
// master = datapath (memory bus master, command responder); slave = control unit and memory.
interface acc_datapath_mc_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13,
   parameter int ACC_W  = 2
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [2:0]        cmd_alu;
   logic [ACC_W-1:0]  cmd_dst;
   logic [ADDR_W-1:0] cmd_addr;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  cmd_valid, cmd_op, cmd_alu, cmd_dst, cmd_addr, mem_ack, mem_rdata,
      output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_alu, cmd_dst, cmd_addr, mem_ack, mem_rdata,
      input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/acc_datapath_mc.sv
// Parametrised multicycle accumulator datapath: one micro-command at a time,
// external memory over req/ack with wait states, carry-aware ALU, conditional PC load.
module acc_datapath_mc #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 13,
   parameter int NUM_ACC = 4,
   localparam int ACC_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   acc_datapath_mc_if.master       bus,
   output logic [ADDR_W-1:0]       pc,
   output logic [2:0]              czn,
   input  logic [ACC_W-1:0]        acc_dbg_sel,
   output logic [DATA_W-1:0]       acc_dbg_data,
   output logic                    busy
);

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC} state_e;

   typedef enum logic [2:0] {
      OP_PC_INC  = 3'd0,
      OP_LOAD    = 3'd1,
      OP_STORE   = 3'd2,
      OP_ALU_MEM = 3'd3,
      OP_ALU_ACC = 3'd4,
      OP_JMP     = 3'd5,
      OP_JCOND   = 3'd6,
      OP_CLR_CZN = 3'd7
   } op_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [2:0]        alu_q, alu_d;
   logic [ACC_W-1:0]  dst_q, dst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        czn_q, czn_d;
   logic [DATA_W-1:0] acc_q [NUM_ACC];
   logic [DATA_W-1:0] acc_d [NUM_ACC];

   logic [DATA_W-1:0] alu_a, alu_b, alu_res;
   logic [DATA_W:0]   alu_sum;
   logic              alu_c;
   logic              jc_flag;

   // Second ALU operand: MDR for memory ops, accumulator named by addr low bits otherwise.
   assign alu_a = acc_q[dst_q];
   assign alu_b = (op_q == OP_ALU_MEM) ? mdr_q : acc_q[addr_q[ACC_W-1:0]];

   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_c   = czn_q[0];
      unique case (alu_q)
         3'd0: begin
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            alu_res = alu_sum[DATA_W-1:0];
            alu_c   = alu_sum[DATA_W];
         end
         3'd1: begin
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, czn_q[0]};
            alu_res = alu_sum[DATA_W-1:0];
            alu_c   = alu_sum[DATA_W];
         end
         3'd2: begin
            alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};
            alu_res = alu_sum[DATA_W-1:0];
            alu_c   = alu_sum[DATA_W];
         end
         3'd3:    alu_res = alu_a & alu_b;
         3'd4:    alu_res = alu_a | alu_b;
         3'd5:    alu_res = alu_a ^ alu_b;
         3'd6:    alu_res = ~alu_b;
         default: alu_res = alu_b;
      endcase
   end

   always_comb begin
      unique case (alu_q[1:0])
         2'd0:    jc_flag = czn_q[0];
         2'd1:    jc_flag = czn_q[1];
         2'd2:    jc_flag = czn_q[2];
         default: jc_flag = 1'b1;
      endcase
   end

   always_comb begin
      // NOTE: every _d signal gets its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      op_d    = op_q;
      alu_d   = alu_q;
      dst_d   = dst_q;
      addr_d  = addr_q;
      mdr_d   = mdr_q;
      pc_d    = pc_q;
      czn_d   = czn_q;
      acc_d   = acc_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d   = op_e'(bus.cmd_op);
               alu_d  = bus.cmd_alu;
               dst_d  = bus.cmd_dst;
               addr_d = bus.cmd_addr;
               if (op_e'(bus.cmd_op) inside {OP_LOAD, OP_STORE, OP_ALU_MEM}) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               if (op_q == OP_STORE) begin
                  state_d = S_IDLE;
               end else begin
                  mdr_d   = bus.mem_rdata;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            unique case (op_q)
               OP_PC_INC: pc_d = pc_q + ADDR_W'(1);
               OP_LOAD:   acc_d[dst_q] = mdr_q;
               OP_ALU_MEM, OP_ALU_ACC: begin
                  acc_d[dst_q] = alu_res;
                  czn_d = {alu_res[DATA_W-1], (alu_res == '0), alu_c};
               end
               OP_JMP:    pc_d = addr_q;
               OP_JCOND:  if (jc_flag ^ alu_q[2]) pc_d = addr_q;
               OP_CLR_CZN: czn_d = '0;
               default:   ;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_PC_INC;
         alu_q   <= '0;
         dst_q   <= '0;
         addr_q  <= '0;
         mdr_q   <= '0;
         pc_q    <= '0;
         czn_q   <= '0;
         // NOTE: the accumulator file is architecturally visible state, so unlike a RAM it is reset.
         for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         op_q    <= op_d;
         alu_q   <= alu_d;
         dst_q   <= dst_d;
         addr_q  <= addr_d;
         mdr_q   <= mdr_d;
         pc_q    <= pc_d;
         czn_q   <= czn_d;
         acc_q   <= acc_d;
      end
   end

   // Memory outputs decode straight from the MEM state so reset drops mem_req with no extra edge.
   assign bus.mem_req   = (state_q == S_MEM);
   assign bus.mem_we    = (state_q == S_MEM) && (op_q == OP_STORE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = acc_q[dst_q];

   assign bus.cmd_ready    = (state_q == S_IDLE);
   assign busy             = (state_q != S_IDLE);
   assign pc               = pc_q;
   assign czn              = czn_q;
   assign acc_dbg_data     = acc_q[acc_dbg_sel];

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Directed self-checking bench for acc_datapath_mc with a hand-driven memory responder.
module tb_acc_datapath_mc;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 13;
   localparam int NUM_ACC = 4;
   localparam int ACC_W = 2;

   localparam logic [2:0] PC_INC = 3'd0, LOAD = 3'd1, STORE = 3'd2, ALU_MEM = 3'd3,
                          ALU_ACC = 3'd4, JMP = 3'd5, JCOND = 3'd6, CLR_CZN = 3'd7;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        czn;
   logic [ACC_W-1:0]  acc_dbg_sel;
   logic [DATA_W-1:0] acc_dbg_data;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   int                req_cycles;
   logic              addr_ok;
   logic              we_seen;
   logic [DATA_W-1:0] wdata_seen;

   acc_datapath_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus_if ();

   acc_datapath_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ACC(NUM_ACC)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus_if.master),
      .pc           (pc),
      .czn          (czn),
      .acc_dbg_sel  (acc_dbg_sel),
      .acc_dbg_data (acc_dbg_data),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic read_acc(input logic [ACC_W-1:0] sel, output logic [DATA_W-1:0] val);
      acc_dbg_sel = sel;
      #1;
      val = acc_dbg_data;
   endtask

   // Offers one command, answers memory after 'waits' wait cycles, and checks accept-to-idle latency.
   task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] alu,
                        input logic [ACC_W-1:0] dst, input logic [ADDR_W-1:0] addr,
                        input int waits, input logic [DATA_W-1:0] rdata);
      int guard;
      int lat;
      int w;
      int exp_lat;
      @(negedge clk);
      guard = 0;
      while (!bus_if.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = op;
      bus_if.cmd_alu   = alu;
      bus_if.cmd_dst   = dst;
      bus_if.cmd_addr  = addr;
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      lat = 1;
      w = 0;
      req_cycles = 0;
      addr_ok = 1'b1;
      while (!bus_if.cmd_ready && lat < 64) begin
         if (bus_if.mem_req) begin
            req_cycles++;
            if (bus_if.mem_addr !== addr) addr_ok = 1'b0;
            we_seen    = bus_if.mem_we;
            wdata_seen = bus_if.mem_wdata;
            bus_if.mem_ack   = (w == waits);
            bus_if.mem_rdata = rdata;
            w++;
         end
         @(negedge clk);
         bus_if.mem_ack = 1'b0;
         lat++;
      end
      if (op == STORE)                    exp_lat = 2 + waits;
      else if (op == LOAD || op == ALU_MEM) exp_lat = 3 + waits;
      else                                exp_lat = 2;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (op == LOAD || op == STORE || op == ALU_MEM) begin
         check({tag, "_req_cycles"}, 32'(req_cycles), 32'(waits + 1));
         check({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
      end
   endtask

   logic [DATA_W-1:0] v;
   int                acc_cnt;
   int                w;
   logic              took;

   initial begin
      rst = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = '0;
      bus_if.cmd_alu   = '0;
      bus_if.cmd_dst   = '0;
      bus_if.cmd_addr  = '0;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = '0;
      acc_dbg_sel      = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_czn", 32'(czn), 32'h0);

      // LOAD with three wait cycles from the top address.
      issue("load_a5", LOAD, 3'd0, 2'd2, 13'h1FFF, 3, 8'hA5);
      check("load_a5_we", 32'(we_seen), 32'd0);
      read_acc(2'd2, v);
      check("load_a5_acc2", 32'(v), 32'hA5);
      check("load_a5_czn", 32'(czn), 32'h0);

      // ADD with carry out, then ADC folds the carry in.
      issue("ld_acc0", LOAD, 3'd0, 2'd0, 13'h0001, 0, 8'hF0);
      issue("add", ALU_MEM, 3'd0, 2'd0, 13'h0002, 1, 8'h20);
      read_acc(2'd0, v);
      check("add_acc0", 32'(v), 32'h10);
      check("add_czn", 32'(czn), 32'b001);
      issue("adc", ALU_MEM, 3'd1, 2'd0, 13'h0003, 0, 8'h00);
      read_acc(2'd0, v);
      check("adc_acc0", 32'(v), 32'h11);
      check("adc_czn", 32'(czn), 32'b000);

      // Register SUB to zero, then conditional jumps on Z.
      issue("ld_acc1", LOAD, 3'd0, 2'd1, 13'h0004, 0, 8'h05);
      issue("ld_acc3", LOAD, 3'd0, 2'd3, 13'h0005, 0, 8'h05);
      issue("sub", ALU_ACC, 3'd2, 2'd1, 13'h0003, 0, 8'h00);
      read_acc(2'd1, v);
      check("sub_acc1", 32'(v), 32'h00);
      check("sub_czn", 32'(czn), 32'b011);
      issue("jz", JCOND, 3'b001, 2'd0, 13'h0ABC, 0, 8'h00);
      check("jz_pc", 32'(pc), 32'h0ABC);
      issue("jnz", JCOND, 3'b101, 2'd0, 13'h0123, 0, 8'h00);
      check("jnz_pc", 32'(pc), 32'h0ABC);

      // Logic ops leave C alone; NOT of memory sets N; CLR_CZN clears everything.
      issue("and", ALU_ACC, 3'd3, 2'd0, 13'h0002, 0, 8'h00);
      read_acc(2'd0, v);
      check("and_acc0", 32'(v), 32'h01);
      check("and_czn", 32'(czn), 32'b001);
      issue("not", ALU_MEM, 3'd6, 2'd0, 13'h0006, 0, 8'h0F);
      read_acc(2'd0, v);
      check("not_acc0", 32'(v), 32'hF0);
      check("not_czn", 32'(czn), 32'b101);
      issue("clr", CLR_CZN, 3'd0, 2'd0, 13'h0000, 0, 8'h00);
      check("clr_czn", 32'(czn), 32'b000);

      // Zero-wait STORE.
      issue("ld_3c", LOAD, 3'd0, 2'd3, 13'h0007, 0, 8'h3C);
      issue("store", STORE, 3'd0, 2'd3, 13'h0040, 0, 8'h00);
      check("store_we", 32'(we_seen), 32'd1);
      check("store_wdata", 32'(wdata_seen), 32'h3C);

      // PC wrap.
      issue("jmp_top", JMP, 3'd0, 2'd0, 13'h1FFF, 0, 8'h00);
      check("jmp_pc", 32'(pc), 32'h1FFF);
      issue("inc_wrap", PC_INC, 3'd0, 2'd0, 13'h0000, 0, 8'h00);
      check("wrap_pc", 32'(pc), 32'h0000);

      // A PC_INC offered while a LOAD is busy must be taken exactly once.
      @(negedge clk);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = LOAD;
      bus_if.cmd_alu   = 3'd0;
      bus_if.cmd_dst   = 2'd1;
      bus_if.cmd_addr  = 13'h0100;
      @(negedge clk);
      bus_if.cmd_op   = PC_INC;
      bus_if.cmd_addr = 13'h0000;
      acc_cnt = 0;
      w = 0;
      for (int c = 0; c < 12; c++) begin
         bus_if.mem_ack   = bus_if.mem_req && (w == 2);
         bus_if.mem_rdata = 8'h77;
         if (bus_if.mem_req) w++;
         took = bus_if.cmd_valid && bus_if.cmd_ready;
         if (took) acc_cnt++;
         @(negedge clk);
         bus_if.mem_ack = 1'b0;
         if (took) bus_if.cmd_valid = 1'b0;
      end
      check("pend_accepts", 32'(acc_cnt), 32'd1);
      check("pend_pc", 32'(pc), 32'h0001);
      read_acc(2'd1, v);
      check("pend_acc1", 32'(v), 32'h77);

      // PASS of a negative value sets N and keeps C.
      issue("pass", ALU_ACC, 3'd7, 2'd0, 13'h0002, 0, 8'h00);
      read_acc(2'd0, v);
      check("pass_acc0", 32'(v), 32'hA5);
      check("pass_czn", 32'(czn), 32'b100);

      // Reset in the middle of a LOAD: request drops at once and nothing is written back.
      @(negedge clk);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = LOAD;
      bus_if.cmd_dst   = 2'd2;
      bus_if.cmd_addr  = 13'h0055;
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      check("mid_mem_req", 32'(bus_if.mem_req), 32'd1);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 8'hEE;
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_req", 32'(bus_if.mem_req), 32'd0);
      check("rst2_pc", 32'(pc), 32'h0);
      check("rst2_czn", 32'(czn), 32'h0);
      for (int i = 0; i < NUM_ACC; i++) begin
         read_acc(ACC_W'(i), v);
         check($sformatf("rst2_acc%0d", i), 32'(v), 32'h0);
      end
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst2_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("rst2_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
